// File: rtl/bcd_stopwatch_counter_pkg.sv
// rtl/bcd_stopwatch_counter_pkg.sv - shared constants and helpers for the BCD stopwatch counter
package bcd_stopwatch_counter_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;
    localparam logic       DIR_UP     = 1'b1;
    localparam logic       DIR_DOWN   = 1'b0;

    // Out-of-range nibbles load as zero so the count never leaves BCD.
    function automatic logic [3:0] sanitize_nib(input logic [3:0] nib);
        return (nib > BCD_MAX) ? 4'd0 : nib;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_counter_bcd_digit.sv
// rtl/bcd_stopwatch_counter_bcd_digit.sv - single decade up/down counter with carry/borrow out
import bcd_stopwatch_counter_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_nib,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);

    assign carry  = (q == BCD_MAX) && (up == DIR_UP) && step;
    assign borrow = (q == 4'd0) && (up == DIR_DOWN) && step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_nib;
        end else if (step) begin
            if (up == DIR_UP) begin
                q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
            end else begin
                q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// rtl/bcd_stopwatch_counter.sv - four-digit BCD up/down counter with prescaler, load and wrap pulse
import bcd_stopwatch_counter_pkg::*;

module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] digits,
    output logic        tick,
    output logic        wrap
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         pre;
    logic [NUM_DIGITS-1:0] step;
    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] borrow;

    assign tick = en && (pre == PRE_LAST) && !reset;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (load) begin
            pre <= '0;
        end else if (en) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    // Each higher digit steps only when every lower digit rolled over on this tick.
    assign step[0] = tick;

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            if (k > 0) begin : g_chain
                assign step[k] = carry[k-1] | borrow[k-1];
            end
            bcd_digit u_digit (
                .clk      (CLOCK_50),
                .rst      (reset),
                .step     (step[k]),
                .up       (up),
                .load     (load),
                .load_nib (sanitize_nib(load_val[4*k +: 4])),
                .q        (digits[4*k +: 4]),
                .carry    (carry[k]),
                .borrow   (borrow[k])
            );
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wrap <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= carry[NUM_DIGITS-1] | borrow[NUM_DIGITS-1];
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// tb/tb_bcd_stopwatch_counter.sv - randomized bench against an integer reference model
module tb_bcd_stopwatch_counter;

    localparam int TD = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] digits;
    logic        tick;
    logic        wrap;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt;
    int m_pre;
    bit m_wrap;

    bcd_stopwatch_counter #(.TICK_DIV(TD)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .digits   (digits),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sanitize(input logic [15:0] v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            int d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) d = 0;
            r += d * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One clock: check tick before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        bit exp_tick;
        #1;
        exp_tick = !reset && en && (m_pre == TD - 1);
        check("tick", tick, exp_tick);
        @(posedge CLOCK_50);
        if (!reset) begin
            if (load) begin
                m_cnt  = sanitize(load_val);
                m_pre  = 0;
                m_wrap = 0;
            end else begin
                m_wrap = 0;
                if (exp_tick) begin
                    if (up) begin
                        m_wrap = (m_cnt == 9999);
                        m_cnt  = (m_cnt + 1) % 10000;
                    end else begin
                        m_wrap = (m_cnt == 0);
                        m_cnt  = (m_cnt + 9999) % 10000;
                    end
                end
                if (en) m_pre = (m_pre + 1) % TD;
            end
        end
        @(negedge CLOCK_50);
        check("digits", digits, to_bcd(m_cnt));
        check("wrap", wrap, m_wrap);
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        check("rst_digits", digits, 16'h0000);
        check("rst_wrap", wrap, 1'b0);
        check("rst_tick", tick, 1'b0);
        m_cnt  = 0;
        m_pre  = 0;
        m_wrap = 0;
        @(negedge CLOCK_50);
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        m_cnt = 0; m_pre = 0; m_wrap = 0;
        @(negedge CLOCK_50);
        cycle();
        reset = 1'b0;

        // Load 0x0123, then reset asynchronously mid-cycle
        do_load(16'h0123);
        check("ld0123", digits, 16'h0123);
        en = 1'b1;
        cycle();
        async_reset();

        // Count up 160 cycles from zero; first tick on the 4th cycle
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 160; i++) cycle();
        check("up160", digits, 16'h0040);

        // Upper wrap
        do_load(16'h9998);
        for (int i = 0; i < 10; i++) cycle();
        check("wrap_up_end", digits, 16'h0000);

        // Lower wrap, then one more step down
        up = 1'b0;
        do_load(16'h0001);
        for (int i = 0; i < 12; i++) cycle();
        check("wrap_dn_end", digits, 16'h9998);

        // Sanitised load, then load coinciding with a tick
        do_load(16'hA5F3);
        check("sanitize", digits, 16'h0503);
        up = 1'b1;
        while (m_pre != TD - 1) cycle();
        do_load(16'h4321);
        check("load_vs_tick", digits, 16'h4321);
        for (int i = 0; i < 6; i++) cycle();

        // Pause with pre at 2 for 10 cycles
        do_load(16'h0000);
        cycle(); cycle();
        en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("pause_hold", digits, 16'h0000);
        en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            load     = ($urandom_range(0, 40) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                       to_bcd(($urandom_range(0, 3) == 0) ? 9999 - $urandom_range(0, 3)
                                                          : $urandom_range(0, 9999));
            if ($urandom_range(0, 400) == 0) begin
                load = 1'b0;
                async_reset();
            end else begin
                cycle();
            end
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_counter.md
# bcd_stopwatch_counter

Four-digit BCD up/down counter with a built-in prescaler. It generates the digit values shown on the board's seven-segment displays. It sits directly upstream of the four hex-to-seven-segment decoders: `digits[3:0]` drives the HEX0 decoder and `digits[15:12]` drives the HEX3 decoder. Counting is paced by an internal tick derived from the 50 MHz board clock. Pause, direction and parallel load are controlled from switches and keys.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count step, giving 1 Hz at 50 MHz. Legal range is ≥1. Benches use 4.
- `CLOCK_50` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset, released synchronously by the board reset logic.
- `en` in 1: 1 = prescaler runs and count steps; 0 = everything frozen (pause).
- `up` in 1: 1 = count up, 0 = count down. Sampled on the tick edge.
- `load` in 1: synchronous parallel load of `load_val`.
- `load_val` in 16: four BCD nibbles, with `[3:0]` as the least significant digit.
- `digits` out 16: registered BCD count, with `[3:0]` as the least significant digit. Feeds the decoders.
- `tick` out 1: one-cycle step strobe.
- `wrap` out 1: registered one-cycle pulse on a 9999↔0000 wrap.

## Operation
- Reset values: `digits`=16'h0000, prescaler=0, `wrap`=0. `tick` is forced to 0 while `reset`=1. Reset mid-count aborts immediately, with no partial step.
- Prescaler `pre`, width ⌈log2(TICK_DIV)⌉ (min 1):
  - When `en`=1, it counts 0…TICK_DIV−1 and then returns to 0.
  - When `en`=0, it holds its value.
- `tick` = `en` & (`pre` == TICK_DIV−1). It is combinational. With TICK_DIV=1, `tick`=`en`.
- Priority per edge, highest first:
  1. `load`=1: load `digits` from `load_val`, clear `pre` to 0, set `wrap` to 0. This applies regardless of `en` or `tick`.
  2. `tick`=1: step `digits` by ±1 in BCD.
  3. Otherwise: hold.
- Load sanitising: any `load_val` nibble > 9 loads as 0 in that digit only; other digits load as given.
- BCD step up:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - 9999 → 0000 and `wrap` pulses.
- BCD step down:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - 0000 → 9999 and `wrap` pulses.
- `digits` never holds a non-BCD nibble.
- `wrap` is 1 only in the cycle after the edge that performed a wrapping step. It is 0 in all other cycles.
- Direction changes take effect on the next tick. There is no effect on `pre`.

## Timing
- The count updates on the rising edge where `tick`=1. The new value is visible on `digits` one cycle later, coincident with `wrap` if it wrapped.
- Steady `en`=1: one step every TICK_DIV cycles. The first step after reset or load happens TICK_DIV cycles after the first edge with `en`=1.
- `en` drop for N cycles: the step is delayed by exactly N cycles, because `pre` is preserved.
- `load` coincident with `tick`: the load wins, the step is lost, and `wrap`=0.
- Reset asserted asynchronously: outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package or header: `BCD_MAX`=4'd9, `NUM_DIGITS`=4, and the up/down encoding constants.
- One sub-module, `bcd_digit`, instantiated four times in a ripple chain. It is a single decade counter with:
  - inputs: `step`, `up`, `load`, `load_nib`;
  - outputs: `q[3:0]`, `carry` (q==9 & up & step) and `borrow` (q==0 & ~up & step).
  - The `step` of digit k = `tick` AND (carry/borrow of digit k−1). Digit 0 uses `tick`.
- `wrap` = registered (carry | borrow) of digit 3.
- Top level holds the prescaler, priority logic, `wrap` register and `load_val` sanitising. It contains no decoder logic; the segment decoders stay separate.

## Test plan
All scenarios use TICK_DIV=4.
1. Reset while `digits`=0x0123 → `digits`=0x0000, `wrap`=0 and `tick`=0 immediately. After release with `en`=1, the first `tick` appears on cycle 4.
2. `en`=1, `up`=1, count from 0x0000:
   - `digits` reads 0x0009 and then 0x0010 across successive ticks (decade carry, no 0x000A).
   - 40 ticks gives 0x0040 after 160 cycles.
3. Load 0x9998, `up`=1, two ticks → 0x9999, then 0x0000 with `wrap`=1 for exactly one cycle.
4. Load 0x0001, `up`=0, two ticks → 0x0000, then 0x9999 with `wrap`=1. A third tick gives 0x9998 with `wrap`=0.
5. Load and pause:
   - `load_val`=0xA5F3 → `digits`=0x0503.
   - `load` asserted in the same cycle as `tick` → the loaded value holds with no step. The next tick comes 4 cycles later.
6. `pre`=2 when `en` drops for 10 cycles → `digits` unchanged. The tick arrives 2 cycles after `en` returns (cycle 12 overall).
